// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low column drive, 2-flop row sync, per-scan debounce, 0-F key code.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_SCANS scans while a key stays held.
module keypad_scanner #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int         PW  = $clog2(SCAN_DIV);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HELD, S_RELEASE} state_e;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   hits_q, hits_d, cur_hits;
  logic          tick, eos, single, accept;
  logic [4:0]    n_hits;
  logic [3:0]    hit_idx, scan_key;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d, cand_q, cand_d, code_q, code_d;
  logic          valid_q, valid_d, held_q, held_d;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  // Hit bit index is {row, column}.
  function automatic logic [3:0] keymap(input logic [3:0] idx);
    case (idx)
      4'd0:  keymap = 4'h1;  4'd1:  keymap = 4'h2;  4'd2:  keymap = 4'h3;  4'd3:  keymap = 4'hA;
      4'd4:  keymap = 4'h4;  4'd5:  keymap = 4'h5;  4'd6:  keymap = 4'h6;  4'd7:  keymap = 4'hB;
      4'd8:  keymap = 4'h7;  4'd9:  keymap = 4'h8;  4'd10: keymap = 4'h9;  4'd11: keymap = 4'hC;
      4'd12: keymap = 4'h0;  4'd13: keymap = 4'hF;  4'd14: keymap = 4'hE;  default: keymap = 4'hD;
    endcase
  endfunction

  always_comb begin
    tick     = (presc_q == PW'(SCAN_DIV - 1));
    eos      = tick && (idx_q == 2'd3);
    presc_d  = tick ? '0 : presc_q + PW'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    cur_hits = hits_q;
    for (int r = 0; r < 4; r++) cur_hits[{2'(r), idx_q}] = ~row_s2_q[r];
    hits_d   = tick ? cur_hits : hits_q;
    n_hits   = '0;
    hit_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (cur_hits[i]) begin
        n_hits  = n_hits + 5'd1;
        hit_idx = 4'(i);
      end
    end
    single   = (n_hits == 5'd1);
    scan_key = keymap(hit_idx);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      presc_q  <= '0;
      idx_q    <= '0;
      hits_q   <= '0;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      hits_q   <= hits_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // MULTI scans are deliberately treated like NONE: only !single matters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (eos) begin
      case (state_q)
        S_IDLE: begin
          if (single) begin
            cand_d  = scan_key;
            cnt_d   = 4'd1;
            state_d = S_CONFIRM;
            if (DEB == 4'd1) accept = 1'b1;
          end
        end
        S_CONFIRM: begin
          if (single && scan_key == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 >= DEB) accept = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          if (single && scan_key == cand_q) begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_q == RW'(REPEAT_SCANS - 1)) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_q + RW'(1);
            end
`endif
          end else begin
            state_d = S_RELEASE;
            cnt_d   = single ? 4'd0 : 4'd1;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
            if (!single && DEB == 4'd1) begin
              held_d  = 1'b0;
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end
        end
        S_RELEASE: begin
          if (!single) begin
            if (cnt_q + 4'd1 >= DEB) begin
              held_d  = 1'b0;
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (scan_key == cand_q) begin
            state_d = S_HELD;
            cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (accept) begin
        code_d  = cand_d;
        valid_d = 1'b1;
        held_d  = 1'b1;
        state_d = S_HELD;
        cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = '0;
`endif
      end
    end
  end

  always_comb begin
    col       = ~(4'b0001 << idx_q);
    key_code  = code_q;
    key_valid = valid_q;
    key_held  = held_q;
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: scan-level behavioural model checked every cycle plus literal checks.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 5;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held;
  logic [15:0] pressed = '0;

  int n_checks = 0;
  int n_errors = 0;
  int abs_cyc = 0;
  int pulses = 0;
  int last_pulse = 0;

  int         key_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  logic [3:0] col_seq [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  bit m_live = 1'b0;
  bit m_held, m_valid;
  int m_cyc, m_code, last_res, run_len, m_rep;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(REP)) dut (
    .clk(clk), .clr(clr), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // Keypad: a pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && col[c] == 1'b0) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, abs_cyc);
    end
  endtask

  // Scan-level model: runs of identical scan results decide press, release and repeat.
  task automatic model_scan();
    int n, res, prev;
    n = 0;
    res = -1;
    for (int i = 0; i < 16; i++) if (pressed[i]) begin n++; res = key_tab[i]; end
    if (n != 1) res = -1;
    prev = last_res;
    if (res == last_res) run_len++; else run_len = 1;
    last_res = res;
    if (!m_held) begin
      if (res >= 0 && run_len == DEB) begin
        m_code = res; m_valid = 1'b1; m_held = 1'b1; m_rep = 0;
      end
    end else if (res < 0) begin
      if (run_len == DEB) m_held = 1'b0;
    end else if (res == m_code) begin
`ifdef KEYPAD_REPEAT_EN
      if (prev == m_code) begin
        m_rep++;
        if (m_rep == REP) begin m_valid = 1'b1; m_rep = 0; end
      end else m_rep = 0;
`else
      m_rep = prev;
`endif
    end
  endtask

  always @(posedge clk) begin
    abs_cyc++;
    if (clr) begin
      m_live = 1'b1; m_cyc = 0; m_code = 0; m_held = 1'b0; m_valid = 1'b0;
      last_res = -1; run_len = 0; m_rep = 0;
    end else if (m_live) begin
      m_valid = 1'b0;
      if (m_cyc % SCAN == SCAN - 1) model_scan();
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic [3:0] e_col;
      e_col = ~(4'b0001 << ((m_cyc / SCAN_DIV) % 4));
      check("col", col, e_col);
      check("key_code", key_code, m_code[3:0]);
      check("key_valid", key_valid, m_valid);
      check("key_held", key_held, m_held);
    end
    if (key_valid === 1'b1) begin
      pulses++;
      last_pulse = abs_cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    #1;
  endtask

  task automatic run_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
    #1;
  endtask

  initial begin
    int p0, t0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check("col_seq", col, col_seq[i/4]);
      @(negedge clk);
    end
    #1;

    // Steady press of 5 (r1,c1), then release.
    p0 = pulses; t0 = abs_cyc; pressed = 16'h0020;
    run_scans(5);
    check("k5_pulses", pulses - p0, 1);
    check("k5_latency_le67", (last_pulse - t0 <= 67), 1);
    check("k5_code", key_code, 4'h5);
    check("k5_held", key_held, 1'b1);
    pressed = '0;
    run_scans(4);
    check("k5_released", key_held, 1'b0);
    check("k5_code_kept", key_code, 4'h5);

    // Bouncing E (r3,c2): never three consecutive scans.
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      pressed = 16'h4000; run_scans(1);
      pressed = '0;       run_scans(1);
    end
    check("bounce_pulses", pulses - p0, 0);
    check("bounce_code", key_code, 4'h5);

    // A (r0,c3): accept, brief release and re-press, then full release.
    p0 = pulses; pressed = 16'h0008;
    run_scans(4);
    check("kA_pulses", pulses - p0, 1);
    check("kA_code", key_code, 4'hA);
    pressed = '0;       run_scans(2);
    check("kA_held_2none", key_held, 1'b1);
    pressed = 16'h0008; run_scans(2);
    check("kA_repress_held", key_held, 1'b1);
    check("kA_repress_pulses", pulses - p0, 1);
    pressed = '0;       run_scans(2);
    check("kA_held_after2", key_held, 1'b1);
    run_scans(1);
    check("kA_held_after3", key_held, 1'b0);

    // Two keys (1 and 9) together, then 9 released.
    p0 = pulses; pressed = 16'h0401;
    run_scans(4);
    check("multi_pulses", pulses - p0, 0);
    pressed = 16'h0001;
    run_scans(4);
    check("multi_then1_pulses", pulses - p0, 1);
    check("multi_then1_code", key_code, 4'h1);
    pressed = '0;
    run_scans(4);

    // Reset while confirming 9.
    p0 = pulses; pressed = 16'h0400;
    run_scans(2);
    repeat (8) @(negedge clk);
    pressed = '0;
    do_reset();
    run_scans(4);
    check("clr_pulses", pulses - p0, 0);
    check("clr_code", key_code, 4'h0);
    check("clr_held", key_held, 1'b0);

    // Long hold of 9 (r2,c2).
    p0 = pulses; pressed = 16'h0400;
    run_scans(14);
`ifdef KEYPAD_REPEAT_EN
    check("hold9_pulses", pulses - p0, 3);
`else
    check("hold9_pulses", pulses - p0, 1);
`endif
    check("hold9_code", key_code, 4'h9);
    pressed = '0;
    run_scans(4);
    check("hold9_released", key_held, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
